// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
// Shared 640x480@60 Hz screen geometry for the VGA timing generator and every
// Render_* block. Holds the raw porch/sync/active numbers, the derived totals
// and sync windows, the 10-bit coordinate type, and two small helpers for
// stepping a raster position and testing coordinate windows.
// ---------------------------------------------------------------------------
package vga_timing_pkg;

    localparam int COORD_W = 10;
    typedef logic [COORD_W-1:0] coord_t;

    // Horizontal geometry, in pixels.
    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;

    // Vertical geometry, in lines.
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;

    localparam int H_TOTAL     = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL     = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HSYNC_START = H_ACTIVE + H_FP;
    localparam int HSYNC_END   = HSYNC_START + H_SYNC - 1;
    localparam int VSYNC_START = V_ACTIVE + V_FP;
    localparam int VSYNC_END   = VSYNC_START + V_SYNC - 1;

    // A raster position; h sits in the upper half so {h, v} packs directly.
    typedef struct packed {
        coord_t h;
        coord_t v;
    } pos_t;

    // One raster step: column advances, wrapping into the next line, and the
    // line wraps back to the top of the frame.
    function automatic pos_t next_pos(pos_t cur, int h_len, int v_len);
        pos_t nxt;
        nxt = cur;
        if (cur.h == coord_t'(h_len - 1)) begin
            nxt.h = '0;
            if (cur.v == coord_t'(v_len - 1)) begin
                nxt.v = '0;
            end else begin
                nxt.v = cur.v + coord_t'(1);
            end
        end else begin
            nxt.h = cur.h + coord_t'(1);
        end
        return nxt;
    endfunction

    // Inclusive window test used for the sync pulses.
    function automatic logic in_range(coord_t x, int lo, int hi);
        return (x >= coord_t'(lo)) && (x <= coord_t'(hi));
    endfunction

endpackage

// File: rtl/vga_timing_gen_raster_counter.sv
// ---------------------------------------------------------------------------
// raster_counter
// A column/line counter pair that walks the raster one position per
// 'advance', wrapping at H_LEN columns and V_LEN lines. Reset loads an
// arbitrary start position so the same block can track either the current
// pixel or a position a fixed number of pixels ahead of it.
//
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset, loads (LOAD_H, LOAD_V)
//   advance  in   step one raster position on this edge
//   h        out  column, 0..H_LEN-1
//   v        out  line,   0..V_LEN-1
// ---------------------------------------------------------------------------
module raster_counter
    import vga_timing_pkg::*;
#(
    parameter int H_LEN  = H_TOTAL,
    parameter int V_LEN  = V_TOTAL,
    parameter int LOAD_H = 0,
    parameter int LOAD_V = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               advance,
    output logic [COORD_W-1:0] h,
    output logic [COORD_W-1:0] v
);

    pos_t stepped;

    assign stepped = next_pos({h, v}, H_LEN, V_LEN);

    always_ff @(posedge clk) begin
        if (rst) begin
            h <= coord_t'(LOAD_H);
            v <= coord_t'(LOAD_V);
        end else if (advance) begin
            h <= stepped.h;
            v <= stepped.v;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
// Generates VGA raster timing (640x480@60 Hz by default) plus the current
// pixel position and a look-ahead position LOOKAHEAD pixels further along
// the raster, so renderers can register a ROM address early and have the
// data land on the matching pixel. Every output is a register.
//
// Ports:
//   clk          in   system clock (PIX_DIV clks per pixel)
//   rst          in   synchronous active-high reset
//   pix_tick     out  high for the clk in which the raster advances
//   h_cnt/v_cnt  out  current column / line
//   ah_cnt/av_cnt out column / line LOOKAHEAD pixels ahead
//   valid        out  current position is inside the visible area
//   hsync/vsync  out  active-low sync pulses
//   line_start   out  high for the whole pixel period of column 0
//   frame_start  out  high for the whole pixel period of (0,0)
//
// The geometry parameters default to the shared package values; they exist
// so the same generator can drive non-standard (e.g. reduced) rasters.
// ---------------------------------------------------------------------------
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int PIX_DIV   = 1,
    parameter int LOOKAHEAD = 2,
    parameter int H_ACT     = H_ACTIVE,
    parameter int H_FRONT   = H_FP,
    parameter int H_PULSE   = H_SYNC,
    parameter int H_BACK    = H_BP,
    parameter int V_ACT     = V_ACTIVE,
    parameter int V_FRONT   = V_FP,
    parameter int V_PULSE   = V_SYNC,
    parameter int V_BACK    = V_BP
) (
    input  logic               clk,
    input  logic               rst,
    output logic               pix_tick,
    output logic [COORD_W-1:0] h_cnt,
    output logic [COORD_W-1:0] v_cnt,
    output logic [COORD_W-1:0] ah_cnt,
    output logic [COORD_W-1:0] av_cnt,
    output logic               valid,
    output logic               hsync,
    output logic               vsync,
    output logic               line_start,
    output logic               frame_start
);

    localparam int H_LEN    = H_ACT + H_FRONT + H_PULSE + H_BACK;
    localparam int V_LEN    = V_ACT + V_FRONT + V_PULSE + V_BACK;
    localparam int HS_FIRST = H_ACT + H_FRONT;
    localparam int HS_LAST  = HS_FIRST + H_PULSE - 1;
    localparam int VS_FIRST = V_ACT + V_FRONT;
    localparam int VS_LAST  = VS_FIRST + V_PULSE - 1;

    // The look-ahead pair starts LOOKAHEAD pixels down the raster from (0,0)
    // and then steps in lockstep, so it never needs a multiply or divide.
    localparam int LOAD_H = LOOKAHEAD % H_LEN;
    localparam int LOAD_V = LOOKAHEAD / H_LEN;

    localparam int                DIV_W    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(PIX_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_next;
    logic             advance;
    pos_t             cur_next;

    // The raster steps on the last clk of each pixel period. The per-position
    // flags below are derived from the position the counters are about to
    // hold, so they register on the same edge and stay aligned with h/v_cnt.
    always_comb begin
        advance  = (div_cnt == DIV_LAST);
        div_next = advance ? '0 : div_cnt + DIV_W'(1);
        cur_next = {h_cnt, v_cnt};
        if (advance) begin
            cur_next = next_pos({h_cnt, v_cnt}, H_LEN, V_LEN);
        end
    end

    raster_counter #(
        .H_LEN  (H_LEN),
        .V_LEN  (V_LEN),
        .LOAD_H (0),
        .LOAD_V (0)
    ) u_pos (
        .clk     (clk),
        .rst     (rst),
        .advance (advance),
        .h       (h_cnt),
        .v       (v_cnt)
    );

    raster_counter #(
        .H_LEN  (H_LEN),
        .V_LEN  (V_LEN),
        .LOAD_H (LOAD_H),
        .LOAD_V (LOAD_V)
    ) u_ahead (
        .clk     (clk),
        .rst     (rst),
        .advance (advance),
        .h       (ah_cnt),
        .v       (av_cnt)
    );

    // Strobes only change when the raster moves, which stretches them over
    // the full pixel period. Reset clears them and nothing re-raises them
    // until a real step lands on column 0, so the reset frame is silent.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt     <= '0;
            pix_tick    <= 1'b0;
            valid       <= 1'b1;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            div_cnt  <= div_next;
            pix_tick <= (div_next == DIV_LAST);
            valid    <= (cur_next.h < coord_t'(H_ACT)) && (cur_next.v < coord_t'(V_ACT));
            hsync    <= !in_range(cur_next.h, HS_FIRST, HS_LAST);
            vsync    <= !in_range(cur_next.v, VS_FIRST, VS_LAST);
            if (advance) begin
                line_start  <= (cur_next.h == '0);
                frame_start <= (cur_next.h == '0) && (cur_next.v == '0);
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
// Four generators share one clock and reset: the standard 640x480 raster,
// and a reduced 25x15 raster in three flavours (look-ahead 2, PIX_DIV=4 with
// a look-ahead that spills into the next line, and look-ahead 0). A model
// derives every output from the number of clks since the last reset edge.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Clks elapsed since the last edge that sampled rst high.
    int n    = 0;
    bit live = 1'b0;

    typedef struct packed {
        logic [9:0] h;
        logic [9:0] v;
        logic [9:0] ah;
        logic [9:0] av;
        logic       valid;
        logic       hsync;
        logic       vsync;
        logic       tick;
        logic       ls;
        logic       fs;
    } obs_t;

    obs_t oa, ob, oc, od;

    vga_timing_gen #(.PIX_DIV(1), .LOOKAHEAD(2)) dut_a (
        .clk(clk), .rst(rst), .pix_tick(oa.tick),
        .h_cnt(oa.h), .v_cnt(oa.v), .ah_cnt(oa.ah), .av_cnt(oa.av),
        .valid(oa.valid), .hsync(oa.hsync), .vsync(oa.vsync),
        .line_start(oa.ls), .frame_start(oa.fs)
    );

    vga_timing_gen #(.PIX_DIV(1), .LOOKAHEAD(2),
        .H_ACT(16), .H_FRONT(2), .H_PULSE(4), .H_BACK(3),
        .V_ACT(8), .V_FRONT(2), .V_PULSE(2), .V_BACK(3)) dut_b (
        .clk(clk), .rst(rst), .pix_tick(ob.tick),
        .h_cnt(ob.h), .v_cnt(ob.v), .ah_cnt(ob.ah), .av_cnt(ob.av),
        .valid(ob.valid), .hsync(ob.hsync), .vsync(ob.vsync),
        .line_start(ob.ls), .frame_start(ob.fs)
    );

    vga_timing_gen #(.PIX_DIV(4), .LOOKAHEAD(30),
        .H_ACT(16), .H_FRONT(2), .H_PULSE(4), .H_BACK(3),
        .V_ACT(8), .V_FRONT(2), .V_PULSE(2), .V_BACK(3)) dut_c (
        .clk(clk), .rst(rst), .pix_tick(oc.tick),
        .h_cnt(oc.h), .v_cnt(oc.v), .ah_cnt(oc.ah), .av_cnt(oc.av),
        .valid(oc.valid), .hsync(oc.hsync), .vsync(oc.vsync),
        .line_start(oc.ls), .frame_start(oc.fs)
    );

    vga_timing_gen #(.PIX_DIV(1), .LOOKAHEAD(0),
        .H_ACT(16), .H_FRONT(2), .H_PULSE(4), .H_BACK(3),
        .V_ACT(8), .V_FRONT(2), .V_PULSE(2), .V_BACK(3)) dut_d (
        .clk(clk), .rst(rst), .pix_tick(od.tick),
        .h_cnt(od.h), .v_cnt(od.v), .ah_cnt(od.ah), .av_cnt(od.av),
        .valid(od.valid), .hsync(od.hsync), .vsync(od.vsync),
        .line_start(od.ls), .frame_start(od.fs)
    );

    // Linear-index model: pixel index = clks / PIX_DIV, folded into the frame.
    function automatic obs_t model(int nn, int ha, int hf, int hs, int hb,
                                   int va, int vf, int vs, int vb, int d, int la);
        obs_t e;
        int ht  = ha + hf + hs + hb;
        int vt  = va + vf + vs + vb;
        int ft  = ht * vt;
        int p   = nn / d;
        int pos = p % ft;
        int hh  = pos % ht;
        int vv  = pos / ht;
        int q   = (pos + la) % ft;
        e.h     = 10'(hh);
        e.v     = 10'(vv);
        e.ah    = 10'(q % ht);
        e.av    = 10'(q / ht);
        e.valid = (hh < ha) && (vv < va);
        e.hsync = !((hh >= ha + hf) && (hh < ha + hf + hs));
        e.vsync = !((vv >= va + vf) && (vv < va + vf + vs));
        e.tick  = (nn != 0) && ((nn % d) == d - 1);
        e.ls    = (p > 0) && (hh == 0);
        e.fs    = (p > 0) && (pos == 0);
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s at n=%0d: got %0d, expected %0d", nm, n, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input obs_t a, input obs_t e);
        chk({tag, ".h_cnt"},       32'(a.h),     32'(e.h));
        chk({tag, ".v_cnt"},       32'(a.v),     32'(e.v));
        chk({tag, ".ah_cnt"},      32'(a.ah),    32'(e.ah));
        chk({tag, ".av_cnt"},      32'(a.av),    32'(e.av));
        chk({tag, ".valid"},       32'(a.valid), 32'(e.valid));
        chk({tag, ".hsync"},       32'(a.hsync), 32'(e.hsync));
        chk({tag, ".vsync"},       32'(a.vsync), 32'(e.vsync));
        chk({tag, ".pix_tick"},    32'(a.tick),  32'(e.tick));
        chk({tag, ".line_start"},  32'(a.ls),    32'(e.ls));
        chk({tag, ".frame_start"}, 32'(a.fs),    32'(e.fs));
    endtask

    always @(posedge clk) begin
        if (rst) begin
            n    = 0;
            live = 1'b1;
        end else if (live) begin
            n = n + 1;
        end
    end

    always @(negedge clk) begin
        if (live) begin
            checkOutput("a", oa, model(n, 640, 16, 96, 48, 480, 10, 2, 33, 1, 2));
            checkOutput("b", ob, model(n, 16, 2, 4, 3, 8, 2, 2, 3, 1, 2));
            checkOutput("c", oc, model(n, 16, 2, 4, 3, 8, 2, 2, 3, 4, 30));
            checkOutput("d", od, model(n, 16, 2, 4, 3, 8, 2, 2, 3, 1, 0));
        end
    end

    task automatic step(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int run_clks, input int rst_clks);
        step(run_clks);
        rst = 1'b1;
        step(rst_clks);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        step(5);
        rst = 1'b0;

        chk("a reset h", 32'(oa.h), 0);
        chk("a reset v", 32'(oa.v), 0);
        chk("a reset ah", 32'(oa.ah), 2);
        chk("a reset av", 32'(oa.av), 0);
        chk("a reset hsync", 32'(oa.hsync), 1);
        chk("a reset vsync", 32'(oa.vsync), 1);
        chk("a reset valid", 32'(oa.valid), 1);
        chk("a reset frame_start", 32'(oa.fs), 0);
        chk("a reset pix_tick", 32'(oa.tick), 0);
        chk("c reset ah", 32'(oc.ah), 5);
        chk("c reset av", 32'(oc.av), 1);

        step(100);
        chk("c line1 h", 32'(oc.h), 0);
        chk("c line1 v", 32'(oc.v), 1);
        chk("c line1 line_start", 32'(oc.ls), 1);
        step(3);
        chk("c line_start 4th clk", 32'(oc.ls), 1);
        chk("c h held 4 clks", 32'(oc.h), 0);
        step(1);
        chk("c line_start drop", 32'(oc.ls), 0);
        chk("c h next pixel", 32'(oc.h), 1);

        step(270);
        chk("b last h", 32'(ob.h), 24);
        chk("b last v", 32'(ob.v), 14);
        chk("b wrap ah", 32'(ob.ah), 1);
        chk("b wrap av", 32'(ob.av), 0);
        chk("b pre frame_start", 32'(ob.fs), 0);
        step(1);
        chk("b frame_start", 32'(ob.fs), 1);
        chk("d frame_start", 32'(od.fs), 1);

        step(280);
        chk("a hsync at 655", 32'(oa.hsync), 1);
        step(1);
        chk("a hsync at 656", 32'(oa.hsync), 0);
        step(95);
        chk("a hsync at 751", 32'(oa.hsync), 0);
        step(1);
        chk("a hsync at 752", 32'(oa.hsync), 1);

        step(46);
        chk("a h at 798", 32'(oa.h), 798);
        chk("a ah at 798", 32'(oa.ah), 0);
        chk("a av at 798", 32'(oa.av), 1);
        step(1);
        chk("a h at 799", 32'(oa.h), 799);
        chk("a v at 799", 32'(oa.v), 0);
        step(1);
        chk("a h after wrap", 32'(oa.h), 0);
        chk("a v after wrap", 32'(oa.v), 1);
        chk("a line_start after wrap", 32'(oa.ls), 1);

        // Land dut_b inside both sync pulses, then hit it with a 1-clk reset.
        step(219);
        chk("b pre-reset h", 32'(ob.h), 19);
        chk("b pre-reset v", 32'(ob.v), 10);
        chk("b pre-reset hsync", 32'(ob.hsync), 0);
        chk("b pre-reset vsync", 32'(ob.vsync), 0);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("b post-reset h", 32'(ob.h), 0);
        chk("b post-reset v", 32'(ob.v), 0);
        chk("b post-reset hsync", 32'(ob.hsync), 1);
        chk("b post-reset vsync", 32'(ob.vsync), 1);
        chk("b post-reset frame_start", 32'(ob.fs), 0);
        step(374);
        chk("b no early frame_start", 32'(ob.fs), 0);
        step(1);
        chk("b frame_start after reset", 32'(ob.fs), 1);

        for (int i = 0; i < 25; i++) begin
            applyStimulus(int'($urandom_range(20, 1200)), int'($urandom_range(1, 3)));
        end
        step(400);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
